axis_result_framer: RTL and testbench
=====================================

Name: axis_result_framer

Overview:
AXI-Stream buffering stage directly downstream of the coprocessor's M_AXIS result port. It feeds the DMA S2MM channel. It buffers result words in a small FIFO and regenerates TLAST every PKT_LEN words, so that DMA transfers terminate correctly regardless of upstream TLAST quality. It also reports upstream TLAST misplacement and counts completed output packets.

Parameters:
DATA_WIDTH, 32, width of TDATA on both sides
PKT_LEN, 4, words per output packet; must be >= 1
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  synchronous reset, active-high
S_AXIS_TREADY  output  1  framer can accept a word
S_AXIS_TDATA  input  DATA_WIDTH  result word from coprocessor
S_AXIS_TLAST  input  1  upstream end-of-packet marker; checked, not forwarded
S_AXIS_TVALID  input  1  upstream word valid
M_AXIS_TVALID  output  1  word available to DMA
M_AXIS_TDATA  output  DATA_WIDTH  buffered word
M_AXIS_TLAST  output  1  regenerated end-of-packet marker
M_AXIS_TREADY  input  1  DMA accepts word
pkt_count  output  16  output packets completed (handshake with TLAST)
err_tlast  output  1  sticky: upstream TLAST position mismatch
clear_err  input  1  clears err_tlast

Behaviour:
- Reset (ARESET high at a clock edge): the following all go to 0:
  - write pointer, read pointer, occupancy
  - in_idx, err_tlast, pkt_count
- Outputs while ARESET is high:
  - S_AXIS_TREADY = 0 while ARESET is high, regardless of state.
  - M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, M_AXIS_TLAST = 0 after the reset edge.
- Reset mid-packet discards all buffered words and the partial packet index. No output is generated for discarded data.
- Push condition: S_AXIS_TVALID & S_AXIS_TREADY.
- Pop condition: M_AXIS_TVALID & M_AXIS_TREADY.
- S_AXIS_TREADY = !full & !ARESET. This is combinational from occupancy and does not depend on S_AXIS_TVALID.
- M_AXIS_TVALID = !empty. When empty, M_AXIS_TDATA and M_AXIS_TLAST are forced to 0.
- FIFO storage:
  - Each entry holds {tlast_gen, data}.
  - Storage is a register array with a first-word-fall-through read.
  - A word pushed at edge k is presented on M_AXIS_* in the cycle after edge k (1-cycle latency through an empty FIFO).
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Pointer wrap-around: pointers are log2(DEPTH)+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.
- Full FIFO: TREADY = 0, so no push occurs; a pop in the same cycle frees a slot for the next cycle (no same-cycle bypass).
- Empty FIFO: a pop cannot occur.
- Frame generation:
  - in_idx counts accepted input words from 0 to PKT_LEN-1, then wraps to 0.
  - Each pushed entry stores tlast_gen = (in_idx == PKT_LEN-1).
  - PKT_LEN = 1: every word carries TLAST.
- TLAST check:
  - On each push, compare S_AXIS_TLAST with (in_idx == PKT_LEN-1).
  - On mismatch, err_tlast is set to 1 next cycle. This covers both an early TLAST and a missing TLAST.
  - No resynchronisation: in_idx continues counting, and the framer is authoritative.
- err_tlast clearing: clear_err = 1 clears err_tlast. If a set and a clear occur in the same cycle, the set wins.
- pkt_count increments on a pop with M_AXIS_TLAST = 1 and wraps from 0xFFFF to 0.
- Output stability: M_AXIS_TDATA and M_AXIS_TLAST hold stable while M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0.

Test Plan:
- Reset check: hold ARESET 3 cycles, then release -> S_AXIS_TREADY = 0 during reset and 1 the cycle after; M_AXIS_TVALID = 0; pkt_count = 0; err_tlast = 0.
- Normal streaming (PKT_LEN=4, M_AXIS_TREADY=1): push 0x0FFFFFFE, 0x00FFFFFE, 0x1, 0x2 with TLAST on the 4th -> the same words appear one cycle after each push, M_AXIS_TLAST only on 0x2, pkt_count = 1, err_tlast = 0.
- Backpressure and full: M_AXIS_TREADY = 0, push 10 words continuously -> TREADY drops after 8 accepts. Then raise TREADY with TVALID held -> 10 words in order, no loss or duplication, TLAST on words 4 and 8, simultaneous push/pop keeps occupancy at 8.
- Early TLAST: push 2 words with TLAST on the 2nd -> err_tlast = 1 next cycle. The output still carries TLAST only after the 4th word, and err_tlast stays 1.
- Clear error: pulse clear_err alone -> err_tlast = 0. Pulse clear_err in the same cycle as a missing-TLAST 4th word -> err_tlast = 1.
- Reset mid-packet: after 2 of 4 words are buffered, assert ARESET for 1 cycle -> empty, in_idx = 0. The next 4 words form one packet with TLAST on the 4th word.

Source files
------------

// File: rtl/axis_result_framer.sv
// ---------------------------------------------------------------------------
// axis_result_framer
//
// Purpose:
//   Buffers result words from the coprocessor's M_AXIS port in a small
//   first-word-fall-through FIFO and feeds them to the DMA S2MM channel.
//   TLAST on the output is regenerated every PKT_LEN words, so DMA transfers
//   always terminate on a packet boundary whatever the upstream TLAST looks
//   like. The upstream TLAST is only checked: a misplaced one sets the sticky
//   err_tlast flag. Completed output packets are counted in pkt_count.
//
// Parameters:
//   DATA_WIDTH - TDATA width on both sides
//   PKT_LEN    - words per output packet (>= 1)
//   DEPTH      - FIFO entries (power of two, >= 2)
//
// Ports:
//   ACLK           in   clock, all logic on the rising edge
//   ARESET         in   synchronous reset, active-high
//   S_AXIS_TREADY  out  framer can accept a word
//   S_AXIS_TDATA   in   result word from the coprocessor
//   S_AXIS_TLAST   in   upstream end-of-packet marker (checked, not forwarded)
//   S_AXIS_TVALID  in   upstream word valid
//   M_AXIS_TVALID  out  word available to the DMA
//   M_AXIS_TDATA   out  buffered word (0 while empty)
//   M_AXIS_TLAST   out  regenerated end-of-packet marker (0 while empty)
//   M_AXIS_TREADY  in   DMA accepts the word
//   pkt_count      out  output packets completed, wraps at 16 bits
//   err_tlast      out  sticky upstream TLAST position mismatch
//   clear_err      in   clears err_tlast (a same-cycle set wins)
// ---------------------------------------------------------------------------
module axis_result_framer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,

    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,

    output logic [15:0]           pkt_count,
    output logic                  err_tlast,
    input  logic                  clear_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Keep the index at least one bit wide so PKT_LEN = 1 still elaborates.
    localparam int unsigned IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    // Entry layout: {tlast_gen, data}
    logic [DATA_WIDTH:0] r_mem [DEPTH];

    // One extra pointer bit distinguishes full from empty; occupancy is the
    // pointer difference.
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [IW-1:0]       r_in_idx;
    logic                r_err_tlast;
    logic [15:0]         r_pkt_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_last_slot;
    logic [DATA_WIDTH:0] w_rd_entry;

    // -----------------------------------------------------------------------
    // Status and handshakes
    // -----------------------------------------------------------------------
    always_comb begin
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_last_slot = (r_in_idx == LAST_IDX);
        w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];
    end

    always_comb begin
        // Ready only from occupancy and reset, never from TVALID.
        S_AXIS_TREADY = !w_full && !ARESET;
        M_AXIS_TVALID = !w_empty;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        if (!w_empty) begin
            M_AXIS_TDATA = w_rd_entry[DATA_WIDTH-1:0];
            M_AXIS_TLAST = w_rd_entry[DATA_WIDTH];
        end
        w_push = S_AXIS_TVALID && S_AXIS_TREADY;
        w_pop  = M_AXIS_TVALID && M_AXIS_TREADY;
    end

    // -----------------------------------------------------------------------
    // FIFO storage: plain register array, contents need no reset since the
    // pointers define what is valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_last_slot, S_AXIS_TDATA};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame generation: the framer's own word index is authoritative and is
    // never resynchronised to the upstream TLAST.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_in_idx <= '0;
        end else if (w_push) begin
            if (w_last_slot) begin
                r_in_idx <= '0;
            end else begin
                r_in_idx <= r_in_idx + IW'(1);
            end
        end
    end

    // Sticky mismatch flag; a mismatch in the same cycle as clear_err wins.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_err_tlast <= 1'b0;
        end else if (w_push && (S_AXIS_TLAST != w_last_slot)) begin
            r_err_tlast <= 1'b1;
        end else if (clear_err) begin
            r_err_tlast <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pkt_count <= '0;
        end else if (w_pop && M_AXIS_TLAST) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign pkt_count = r_pkt_count;
    assign err_tlast = r_err_tlast;

endmodule

// File: tb/tb_axis_result_framer.sv
module tb_axis_result_framer;

    localparam int unsigned DW      = 32;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned DEPTH   = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TLAST;
    logic          S_AXIS_TVALID;
    logic          M_AXIS_TVALID;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic [15:0]   pkt_count;
    logic          err_tlast;
    logic          clear_err;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard of expected output beats {tlast, data} and the bench's own
    // word index used to predict the regenerated TLAST.
    logic [DW:0] sb_q[$];
    int          exp_idx = 0;

    axis_result_framer #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT_LEN),
        .DEPTH      (DEPTH)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .pkt_count     (pkt_count),
        .err_tlast     (err_tlast),
        .clear_err     (clear_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard, sampled on the falling edge: handshakes seen here complete
    // at the following rising edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            sb_q.delete();
            exp_idx = 0;
        end else begin
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", {31'd0, M_AXIS_TLAST, M_AXIS_TDATA}, 64'd0);
                end else begin
                    chk("out_beat", {31'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {31'd0, sb_q[0]});
                    void'(sb_q.pop_front());
                end
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                sb_q.push_back({(exp_idx == PKT_LEN - 1), S_AXIS_TDATA});
                exp_idx = (exp_idx == PKT_LEN - 1) ? 0 : exp_idx + 1;
            end
        end
    end

    // Present a word and hold it until accepted; returns at posedge + 1.
    task automatic send(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   n;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge ACLK);
            acc = S_AXIS_TREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("send_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic idle();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then confirm the DUT did too.
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1;
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_out_empty", {63'd0, M_AXIS_TVALID}, 64'd0);
    endtask

    initial begin
        ARESET        = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;
        clear_err     = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_s_tready", {63'd0, S_AXIS_TREADY}, 64'd0);
        chk("rst_m_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
        chk("rst_m_tdata", 64'(M_AXIS_TDATA), 64'd0);
        chk("rst_m_tlast", {63'd0, M_AXIS_TLAST}, 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_err", {63'd0, err_tlast}, 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        chk("post_rst_s_tready", {63'd0, S_AXIS_TREADY}, 64'd1);

        // Normal streaming with one-cycle latency
        send(32'h0FFF_FFFE, 1'b0);
        chk("lat_tvalid", {63'd0, M_AXIS_TVALID}, 64'd1);
        chk("lat_tdata", 64'(M_AXIS_TDATA), 64'h0FFF_FFFE);
        send(32'h00FF_FFFE, 1'b0);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0002, 1'b1);
        chk("lat_last_tlast", {63'd0, M_AXIS_TLAST}, 64'd1);
        idle();
        drain();
        chk("norm_pkt_count", 64'(pkt_count), 64'd1);
        chk("norm_err", {63'd0, err_tlast}, 64'd0);

        // Backpressure until full
        M_AXIS_TREADY = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(32'h100 + 32'(i), (i % 4) == 0);
        end
        chk("full_s_tready", {63'd0, S_AXIS_TREADY}, 64'd0);
        S_AXIS_TDATA = 32'h109;
        S_AXIS_TLAST = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        chk("full_hold_tready", {63'd0, S_AXIS_TREADY}, 64'd0);
        chk("stall_tdata", 64'(M_AXIS_TDATA), 64'h101);
        chk("stall_tlast", {63'd0, M_AXIS_TLAST}, 64'd0);
        M_AXIS_TREADY = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            send(32'h100 + 32'(i), (i % 4) == 0);
        end
        idle();
        drain();
        chk("bp_pkt_count", 64'(pkt_count), 64'd4);
        chk("bp_err", {63'd0, err_tlast}, 64'd0);

        // Early upstream TLAST: flagged, output framing unaffected
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b1);
        chk("early_err_set", {63'd0, err_tlast}, 64'd1);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b1);
        idle();
        drain();
        chk("early_err_sticky", {63'd0, err_tlast}, 64'd1);
        chk("early_pkt_count", 64'(pkt_count), 64'd5);

        // Clear alone, then clear colliding with a missing TLAST
        clear_err = 1'b1;
        @(posedge ACLK);
        #1;
        clear_err = 1'b0;
        chk("clear_alone", {63'd0, err_tlast}, 64'd0);
        send(32'hB0, 1'b0);
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        chk("clear_no_err", {63'd0, err_tlast}, 64'd0);
        clear_err = 1'b1;
        send(32'hB3, 1'b0);
        clear_err = 1'b0;
        chk("set_beats_clear", {63'd0, err_tlast}, 64'd1);
        idle();
        drain();
        chk("clear_pkt_count", 64'(pkt_count), 64'd6);

        // Reset mid-packet discards buffered words and the word index
        M_AXIS_TREADY = 1'b0;
        send(32'hC0, 1'b0);
        send(32'hC1, 1'b0);
        idle();
        ARESET = 1'b1;
        #1;
        chk("mid_rst_s_tready", {63'd0, S_AXIS_TREADY}, 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        chk("mid_rst_empty", {63'd0, M_AXIS_TVALID}, 64'd0);
        chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("mid_rst_err", {63'd0, err_tlast}, 64'd0);
        M_AXIS_TREADY = 1'b1;
        send(32'hD0, 1'b0);
        send(32'hD1, 1'b0);
        send(32'hD2, 1'b0);
        send(32'hD3, 1'b1);
        idle();
        drain();
        chk("after_rst_pkt_count", 64'(pkt_count), 64'd1);
        chk("after_rst_err", {63'd0, err_tlast}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
